// File: rtl/mmss_counter.sv
// mmss_counter: MM:SS BCD time-of-day counter clocked at 50 MHz, advanced by
// a synchronized 1 Hz edge and by two set buttons, with Tick/Rollover pulses.
//
// Ports:
//   C_50Mhz  clock, rising edge
//   Rst_n    async active-low reset
//   C_1Hz    1 Hz square wave (async level)
//   En       count enable (sync level)
//   Clr      sync clear to 00:00
//   Set_sec  raw button, +1 second per rising edge
//   Set_min  raw button, +1 minute per rising edge
//   Sec_u/Sec_d/Min_u/Min_d  BCD digits
//   Tick     one-cycle pulse when the digits advance from C_1Hz
//   Rollover one-cycle pulse with Tick on 59:59 -> 00:00
module mmss_counter #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       C_50Mhz,
  input  logic       Rst_n,
  input  logic       C_1Hz,
  input  logic       En,
  input  logic       Clr,
  input  logic       Set_sec,
  input  logic       Set_min,
  output logic [3:0] Sec_u,
  output logic [3:0] Sec_d,
  output logic [3:0] Min_u,
  output logic [3:0] Min_d,
  output logic       Tick,
  output logic       Rollover
);

  localparam int ARM = SYNC_STAGES + 1;
  localparam int AW  = $clog2(ARM + 1);

  // bit 0: C_1Hz, bit 1: Set_sec, bit 2: Set_min
  logic [SYNC_STAGES-1:0][2:0] sync_q;
  logic [2:0]                  prev_q;
  logic [AW-1:0]               arm_q;
  logic                        armed;
  logic [2:0]                  sync_v;
  logic [2:0]                  rise;

  logic [3:0] sec_u_q, sec_d_q, min_u_q, min_d_q;
  logic [3:0] sec_u_d, sec_d_d, min_u_d, min_d_d;
  logic       tick_q, tick_d;
  logic       roll_q, roll_d;
  logic       sec59, min59;

  assign sync_v = sync_q[SYNC_STAGES-1];
  assign armed  = (arm_q == AW'(ARM));
  // Until armed, prev_q still tracks sync_v so a level that is
  // already high at reset release never looks like an edge.
  assign rise   = armed ? (sync_v & ~prev_q) : 3'b000;

  always_ff @(posedge C_50Mhz or negedge Rst_n) begin
    if (!Rst_n) begin
      sync_q <= '0;
      prev_q <= '0;
      arm_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0],
                 {Set_min, Set_sec, C_1Hz}};
      prev_q <= sync_v;
      if (!armed) arm_q <= arm_q + AW'(1);
    end
  end

  // Two-digit modulo-60 BCD increment {tens, units}.
  function automatic logic [7:0] inc60(
    input logic [3:0] t,
    input logic [3:0] u
  );
    if (u == 4'd9) begin
      if (t == 4'd5) inc60 = 8'h00;
      else           inc60 = {t + 4'd1, 4'd0};
    end else begin
      inc60 = {t, u + 4'd1};
    end
  endfunction

  always_comb begin
    sec_u_d = sec_u_q;
    sec_d_d = sec_d_q;
    min_u_d = min_u_q;
    min_d_d = min_d_q;
    tick_d  = 1'b0;
    roll_d  = 1'b0;
    sec59   = (sec_d_q == 4'd5) && (sec_u_q == 4'd9);
    min59   = (min_d_q == 4'd5) && (min_u_q == 4'd9);
    if (Clr) begin
      sec_u_d = 4'd0;
      sec_d_d = 4'd0;
      min_u_d = 4'd0;
      min_d_d = 4'd0;
    end else if (rise[1] || rise[2]) begin
      // Set edges win over a coincident 1 Hz edge, no carry.
      if (rise[1]) {sec_d_d, sec_u_d} = inc60(sec_d_q, sec_u_q);
      if (rise[2]) {min_d_d, min_u_d} = inc60(min_d_q, min_u_q);
    end else if (rise[0] && En) begin
      tick_d = 1'b1;
      roll_d = sec59 && min59;
      {sec_d_d, sec_u_d} = inc60(sec_d_q, sec_u_q);
      if (sec59) {min_d_d, min_u_d} = inc60(min_d_q, min_u_q);
    end
  end

  always_ff @(posedge C_50Mhz or negedge Rst_n) begin
    if (!Rst_n) begin
      sec_u_q <= '0;
      sec_d_q <= '0;
      min_u_q <= '0;
      min_d_q <= '0;
      tick_q  <= 1'b0;
      roll_q  <= 1'b0;
    end else begin
      sec_u_q <= sec_u_d;
      sec_d_q <= sec_d_d;
      min_u_q <= min_u_d;
      min_d_q <= min_d_d;
      tick_q  <= tick_d;
      roll_q  <= roll_d;
    end
  end

  assign Sec_u    = sec_u_q;
  assign Sec_d    = sec_d_q;
  assign Min_u    = min_u_q;
  assign Min_d    = min_d_q;
  assign Tick     = tick_q;
  assign Rollover = roll_q;

endmodule

// File: tb/tb_mmss_counter.sv
// tb_mmss_counter: drives mmss_counter with directed and random stimulus
// and compares every cycle against an arithmetic MM:SS reference model.
module tb_mmss_counter;

  logic       clk;
  logic       rst_n;
  logic       c1, en, clr, ss_b, sm_b;
  logic [3:0] sec_u, sec_d, min_u, min_d;
  logic       tick, roll;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_mm, m_ss, m_n;
  bit m_tick, m_roll;
  bit h1[4], hs[4], hm[4];

  mmss_counter #(.SYNC_STAGES(2)) dut (
    .C_50Mhz (clk),
    .Rst_n   (rst_n),
    .C_1Hz   (c1),
    .En      (en),
    .Clr     (clr),
    .Set_sec (ss_b),
    .Set_min (sm_b),
    .Sec_u   (sec_u),
    .Sec_d   (sec_d),
    .Min_u   (min_u),
    .Min_d   (min_d),
    .Tick    (tick),
    .Rollover(roll)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mm = 0;
    m_ss = 0;
    m_n = 0;
    m_tick = 0;
    m_roll = 0;
    for (int i = 0; i < 4; i++) begin
      h1[i] = 0;
      hs[i] = 0;
      hm[i] = 0;
    end
  endtask

  // One clock edge of the reference: an input level sampled at edge k
  // is seen as a rise at edge k+2 if it was low at edge k-1, and only
  // from the 4th edge after reset release.
  task automatic model_edge();
    bit e1, es, em;
    int t;
    for (int i = 3; i > 0; i--) begin
      h1[i] = h1[i-1];
      hs[i] = hs[i-1];
      hm[i] = hm[i-1];
    end
    h1[0] = c1;
    hs[0] = ss_b;
    hm[0] = sm_b;
    m_n++;
    e1 = (m_n >= 4) && h1[2] && !h1[3];
    es = (m_n >= 4) && hs[2] && !hs[3];
    em = (m_n >= 4) && hm[2] && !hm[3];
    m_tick = 0;
    m_roll = 0;
    if (clr) begin
      m_mm = 0;
      m_ss = 0;
    end else if (es || em) begin
      if (es) m_ss = (m_ss + 1) % 60;
      if (em) m_mm = (m_mm + 1) % 60;
    end else if (e1 && en) begin
      m_tick = 1;
      m_roll = (m_mm == 59) && (m_ss == 59);
      t = (m_mm * 60 + m_ss + 1) % 3600;
      m_mm = t / 60;
      m_ss = t % 60;
    end
  endtask

  task automatic compare(input string tag);
    chk({tag, ".sec_u"}, int'(sec_u), m_ss % 10);
    chk({tag, ".sec_d"}, int'(sec_d), m_ss / 10);
    chk({tag, ".min_u"}, int'(min_u), m_mm % 10);
    chk({tag, ".min_d"}, int'(min_d), m_mm / 10);
    chk({tag, ".tick"}, int'(tick), int'(m_tick));
    chk({tag, ".roll"}, int'(roll), int'(m_roll));
  endtask

  // Inputs are already set; advance one clock and check.
  task automatic step(input string tag);
    @(posedge clk);
    #1;
    if (rst_n) model_edge();
    else model_reset();
    compare(tag);
  endtask

  task automatic cyc(input int k, input string tag);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      step(tag);
    end
  endtask

  task automatic press_sec(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clk); ss_b = 1'b1;
      step("set_sec");
      cyc(3, "set_sec");
      @(negedge clk); ss_b = 1'b0;
      step("set_sec");
      cyc(3, "set_sec");
    end
  endtask

  task automatic press_min(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clk); sm_b = 1'b1;
      step("set_min");
      cyc(3, "set_min");
      @(negedge clk); sm_b = 1'b0;
      step("set_min");
      cyc(3, "set_min");
    end
  endtask

  task automatic rise_1hz(input string tag);
    @(negedge clk); c1 = 1'b1;
    step(tag);
    cyc(5, tag);
    @(negedge clk); c1 = 1'b0;
    step(tag);
    cyc(5, tag);
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    #1;
    model_reset();
    compare("rst");
    cyc(2, "rst");
    @(negedge clk); rst_n = 1'b1;
    step("release");
  endtask

  int tick_cnt;
  int half;

  initial begin
    rst_n = 1'b1;
    c1 = 1'b1;
    en = 1'b1;
    clr = 1'b0;
    ss_b = 1'b0;
    sm_b = 1'b0;
    model_reset();
    #2 rst_n = 1'b0;
    #1 compare("async_rst0");

    // Release with C_1Hz already high: no tick.
    do_reset();
    tick_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      step("arm");
      tick_cnt += int'(tick);
    end
    chk("arm.no_tick", tick_cnt, 0);
    @(negedge clk); c1 = 1'b0;
    step("arm");
    cyc(5, "arm");

    // 00:58 -> 00:59 -> 01:00
    press_sec(58);
    chk("pre58", int'({min_d, min_u, sec_d, sec_u}), 'h0058);
    rise_1hz("t1");
    rise_1hz("t2");
    chk("t2.val", int'({min_d, min_u, sec_d, sec_u}), 'h0100);

    // 59:59 -> 00:00
    @(negedge clk); clr = 1'b1;
    step("clr");
    @(negedge clk); clr = 1'b0;
    step("clr");
    press_min(59);
    press_sec(59);
    chk("pre5959", int'({min_d, min_u, sec_d, sec_u}), 'h5959);
    rise_1hz("wrap");
    chk("wrap.val", int'({min_d, min_u, sec_d, sec_u}), 'h0000);

    // En = 0: rises ignored; Set_min wraps 59 -> 00
    press_sec(7);
    press_min(59);
    @(negedge clk); en = 1'b0;
    step("dis");
    rise_1hz("dis");
    rise_1hz("dis");
    rise_1hz("dis");
    press_min(1);
    chk("dis.val", int'({min_d, min_u, sec_d, sec_u}), 'h0007);
    @(negedge clk); en = 1'b1;
    step("dis");

    // Set_sec and C_1Hz rise together at 00:30
    @(negedge clk); clr = 1'b1;
    step("clr");
    @(negedge clk); clr = 1'b0;
    step("clr");
    press_sec(30);
    @(negedge clk); c1 = 1'b1; ss_b = 1'b1;
    step("coll");
    cyc(5, "coll");
    @(negedge clk); c1 = 1'b0; ss_b = 1'b0;
    step("coll");
    cyc(5, "coll");
    chk("coll.val", int'({min_d, min_u, sec_d, sec_u}), 'h0031);

    // Clr on the 1 Hz detect cycle at 12:34, then async reset
    @(negedge clk); clr = 1'b1;
    step("clr");
    @(negedge clk); clr = 1'b0;
    step("clr");
    press_min(12);
    press_sec(34);
    @(negedge clk); c1 = 1'b1;
    step("clr1hz");
    cyc(1, "clr1hz");
    @(negedge clk); clr = 1'b1;
    step("clr1hz");
    @(negedge clk); clr = 1'b0;
    step("clr1hz");
    chk("clr1hz.val", int'({min_d, min_u, sec_d, sec_u}), 'h0000);
    press_sec(3);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst.digits", int'({min_d, min_u, sec_d, sec_u}), 0);
    compare("async_rst");
    @(negedge clk); rst_n = 1'b1;
    step("release2");
    c1 = 1'b0;

    // Random phase
    half = 4;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      half--;
      if (half == 0) begin
        c1 = ~c1;
        half = $urandom_range(3, 8);
      end
      if ($urandom_range(0, 11) == 0) ss_b = ~ss_b;
      if ($urandom_range(0, 11) == 0) sm_b = ~sm_b;
      if ($urandom_range(0, 49) == 0) en = ~en;
      clr = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 1999) == 0) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        compare("rnd_rst");
      end else begin
        rst_n = 1'b1;
      end
      step("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
